// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//
// Lets the instruction-fetch (IF) and data-memory (MEM) stages share one
// single-ported unified memory. Requests are granted one at a time to the
// external memory over a req/ack handshake. Read data is returned in
// registered rdata outputs, and a one-cycle ack marks each completion.
// A combinational stall freezes the pipeline while any request is still
// waiting for its ack.
//
// Arbitration: a data request wins over a fetch by default. With the
// ARB_STARVE_GUARD_EN macro defined, a fetch is forced through after
// STARVE_MAX consecutive data grants made while a fetch was waiting.
//
// FSM: IDLE (grant) -> BUSY (memory access) -> DONE (ack pulse) -> IDLE
//
// Ports
//   clk_i, rst_i                     clock (rising edge), async active-high reset
//   if_req_i, if_addr_i              fetch read request and address
//   if_ack_o, if_rdata_o             fetch completion pulse and fetched word
//   dm_req_i, dm_we_i, dm_addr_i,
//   dm_wdata_i                       data read/write request
//   dm_ack_o, dm_rdata_o             data completion pulse and loaded word
//   mem_req_o, mem_we_o, mem_addr_o,
//   mem_wdata_o                      memory request, held until mem_ack_i
//   mem_rdata_i, mem_ack_i           memory read data and completion
//   stall_o                          pipeline stall
module mem_port_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int STARVE_MAX = 3
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              if_req_i,
   input  logic [ADDR_W-1:0] if_addr_i,
   output logic              if_ack_o,
   output logic [DATA_W-1:0] if_rdata_o,
   input  logic              dm_req_i,
   input  logic              dm_we_i,
   input  logic [ADDR_W-1:0] dm_addr_i,
   input  logic [DATA_W-1:0] dm_wdata_i,
   output logic              dm_ack_o,
   output logic [DATA_W-1:0] dm_rdata_o,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic [DATA_W-1:0] mem_rdata_i,
   input  logic              mem_ack_i,
   output logic              stall_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic              grant;
   logic              grant_dm;
   logic              force_if;

   // Transaction captured on the grant edge; the requester inputs are not
   // looked at again until the next grant.
   logic              owner_dm;
   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;

   logic              busy;
   logic              rd_done;

`ifdef ARB_STARVE_GUARD_EN
   localparam int CNT_W = $clog2(STARVE_MAX + 1);

   logic [CNT_W-1:0] starve_cnt;

   // Counts data grants made over a waiting fetch. Once it reaches
   // STARVE_MAX the next contested grant goes to the fetch. It cannot run
   // past STARVE_MAX: at that value a contested grant always goes to IF.
   assign force_if = (starve_cnt == CNT_W'(STARVE_MAX)) & if_req_i & dm_req_i;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         starve_cnt <= '0;
      end else if (grant) begin
         if (grant_dm && if_req_i) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
         end else begin
            starve_cnt <= '0;
         end
      end
   end
`else
   assign force_if = 1'b0;
`endif

   // Next-state and grant decision
   always_comb begin
      state_nxt = state;
      grant     = 1'b0;
      grant_dm  = 1'b0;
      case (state)
         IDLE: begin
            if (if_req_i || dm_req_i) begin
               grant     = 1'b1;
               grant_dm  = dm_req_i & ~force_if;
               state_nxt = BUSY;
            end
         end
         BUSY: begin
            if (mem_ack_i) begin
               state_nxt = DONE;
            end
         end
         // No grant is made here, so a request that is still high after its
         // ack is not serviced a second time.
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Grant-edge capture
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         owner_dm <= 1'b0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
      end else if (grant) begin
         owner_dm <= grant_dm;
         we_q     <= grant_dm & dm_we_i;
         addr_q   <= grant_dm ? dm_addr_i : if_addr_i;
         wdata_q  <= grant_dm ? dm_wdata_i : '0;
      end
   end

   assign busy    = (state == BUSY);
   assign rd_done = busy & mem_ack_i & ~we_q;

   // Read-data return; a write completion leaves both registers untouched
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         if_rdata_o <= '0;
         dm_rdata_o <= '0;
      end else if (rd_done) begin
         if (owner_dm) begin
            dm_rdata_o <= mem_rdata_i;
         end else begin
            if_rdata_o <= mem_rdata_i;
         end
      end
   end

   // Memory-side outputs are decoded from the state register, so an
   // asynchronous reset withdraws mem_req_o immediately.
   assign mem_req_o   = busy;
   assign mem_we_o    = busy & we_q;
   assign mem_addr_o  = busy ? addr_q  : '0;
   assign mem_wdata_o = busy ? wdata_q : '0;

   assign if_ack_o = (state == DONE) & ~owner_dm;
   assign dm_ack_o = (state == DONE) &  owner_dm;

   assign stall_o = (if_req_i & ~if_ack_o) | (dm_req_i & ~dm_ack_o);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter. Covers reset, a single fetch,
// a store followed by a load with memory wait states, simultaneous requests,
// arbitration under continuous requests, reset during BUSY, and spurious
// memory acks.
module tb_mem_port_arbiter;

   localparam int ADDR_W     = 32;
   localparam int DATA_W     = 32;
   localparam int STARVE_MAX = 3;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              if_req = 1'b0;
   logic [ADDR_W-1:0] if_addr = '0;
   logic              if_ack;
   logic [DATA_W-1:0] if_rdata;
   logic              dm_req = 1'b0;
   logic              dm_we = 1'b0;
   logic [ADDR_W-1:0] dm_addr = '0;
   logic [DATA_W-1:0] dm_wdata = '0;
   logic              dm_ack;
   logic [DATA_W-1:0] dm_rdata;
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata = '0;
   logic              mem_ack = 1'b0;
   logic              stall;

   int checks   = 0;
   int failures = 0;

   mem_port_arbiter #(
      .ADDR_W    (ADDR_W),
      .DATA_W    (DATA_W),
      .STARVE_MAX(STARVE_MAX)
   ) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .if_req_i   (if_req),
      .if_addr_i  (if_addr),
      .if_ack_o   (if_ack),
      .if_rdata_o (if_rdata),
      .dm_req_i   (dm_req),
      .dm_we_i    (dm_we),
      .dm_addr_i  (dm_addr),
      .dm_wdata_i (dm_wdata),
      .dm_ack_o   (dm_ack),
      .dm_rdata_o (dm_rdata),
      .mem_req_o  (mem_req),
      .mem_we_o   (mem_we),
      .mem_addr_o (mem_addr),
      .mem_wdata_o(mem_wdata),
      .mem_rdata_i(mem_rdata),
      .mem_ack_i  (mem_ack),
      .stall_o    (stall)
   );

   always #5 clk = ~clk;

   // Inputs change 1 ns after the rising edge; outputs are sampled on the
   // falling edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic test_reset();
      #1 rst = 1'b1;
      #2;
      checks++;
      if ({mem_req, mem_we, if_ack, dm_ack, stall} !== 5'b0) begin
         failures++;
         $display("FAIL reset_ctrl got=%b exp=00000", {mem_req, mem_we, if_ack, dm_ack, stall});
      end
      checks++;
      if ({mem_addr, mem_wdata} !== 64'h0) begin
         failures++;
         $display("FAIL reset_mem_bus got=%h exp=0", {mem_addr, mem_wdata});
      end
      checks++;
      if ({if_rdata, dm_rdata} !== 64'h0) begin
         failures++;
         $display("FAIL reset_rdata got=%h exp=0", {if_rdata, dm_rdata});
      end
      tick();
      tick();
      rst = 1'b0;
      smp();
      checks++;
      if ({mem_req, if_ack, dm_ack, stall} !== 4'b0) begin
         failures++;
         $display("FAIL reset_release_idle got=%b exp=0000", {mem_req, if_ack, dm_ack, stall});
      end
      tick();
   endtask

   task automatic test_single_fetch();
      // cycle 0
      if_req  = 1'b1;
      if_addr = 32'h0000_0010;
      smp();
      checks++;
      if ({stall, mem_req, if_ack} !== 3'b100) begin
         failures++;
         $display("FAIL fetch_c0 got=%b exp=100", {stall, mem_req, if_ack});
      end
      // cycle 1
      tick();
      mem_ack   = 1'b1;
      mem_rdata = 32'h8C01_0004;
      smp();
      checks++;
      if ({stall, mem_req, mem_we, if_ack} !== 4'b1100) begin
         failures++;
         $display("FAIL fetch_c1_ctrl got=%b exp=1100", {stall, mem_req, mem_we, if_ack});
      end
      checks++;
      if (mem_addr !== 32'h0000_0010) begin
         failures++;
         $display("FAIL fetch_c1_addr got=%h exp=00000010", mem_addr);
      end
      // cycle 2
      tick();
      mem_ack   = 1'b0;
      mem_rdata = '0;
      smp();
      checks++;
      if ({if_ack, dm_ack, stall, mem_req} !== 4'b1000) begin
         failures++;
         $display("FAIL fetch_c2_ack got=%b exp=1000", {if_ack, dm_ack, stall, mem_req});
      end
      checks++;
      if (if_rdata !== 32'h8C01_0004) begin
         failures++;
         $display("FAIL fetch_rdata got=%h exp=8c010004", if_rdata);
      end
      // cycle 3
      tick();
      if_req = 1'b0;
      smp();
      checks++;
      if ({if_ack, mem_req, stall} !== 3'b000) begin
         failures++;
         $display("FAIL fetch_c3_idle got=%b exp=000", {if_ack, mem_req, stall});
      end
      tick();
   endtask

   task automatic test_store_load();
      // write, grant cycle 0
      dm_req   = 1'b1;
      dm_we    = 1'b1;
      dm_addr  = 32'h0000_0020;
      dm_wdata = 32'h0000_ABCD;
      smp();
      checks++;
      if ({stall, mem_req} !== 2'b10) begin
         failures++;
         $display("FAIL store_c0 got=%b exp=10", {stall, mem_req});
      end
      for (int b = 1; b <= 3; b++) begin
         tick();
         if (b == 1) begin
            // Inputs change after the grant; the transaction must not follow.
            dm_addr  = 32'h0000_0099;
            dm_wdata = 32'h0000_5555;
            dm_we    = 1'b0;
         end
         mem_ack   = (b == 3);
         mem_rdata = 32'hDEAD_BEEF;
         smp();
         checks++;
         if ({mem_req, mem_we, dm_ack} !== 3'b110 || mem_addr !== 32'h20 || mem_wdata !== 32'hABCD) begin
            failures++;
            $display("FAIL store_busy%0d got=%b/%h/%h exp=110/00000020/0000abcd",
                     b, {mem_req, mem_we, dm_ack}, mem_addr, mem_wdata);
         end
      end
      // cycle 4: ack, rdata untouched by the write
      tick();
      mem_ack = 1'b0;
      smp();
      checks++;
      if ({dm_ack, mem_req} !== 2'b10) begin
         failures++;
         $display("FAIL store_ack got=%b exp=10", {dm_ack, mem_req});
      end
      checks++;
      if (dm_rdata !== 32'h0) begin
         failures++;
         $display("FAIL store_rdata_kept got=%h exp=00000000", dm_rdata);
      end
      // cycle 5: load grant
      tick();
      dm_we    = 1'b0;
      dm_addr  = 32'h0000_0020;
      dm_wdata = '0;
      smp();
      checks++;
      if ({dm_ack, mem_req} !== 2'b00) begin
         failures++;
         $display("FAIL load_c0 got=%b exp=00", {dm_ack, mem_req});
      end
      for (int b = 1; b <= 3; b++) begin
         tick();
         mem_ack   = (b == 3);
         mem_rdata = (b == 3) ? 32'h0000_ABCD : 32'hDEAD_BEEF;
         smp();
         checks++;
         if ({mem_req, mem_we, dm_ack} !== 3'b100 || mem_addr !== 32'h20) begin
            failures++;
            $display("FAIL load_busy%0d got=%b/%h exp=100/00000020",
                     b, {mem_req, mem_we, dm_ack}, mem_addr);
         end
      end
      // cycle 9: ack with data
      tick();
      mem_ack   = 1'b0;
      mem_rdata = '0;
      smp();
      checks++;
      if (dm_ack !== 1'b1 || dm_rdata !== 32'h0000_ABCD) begin
         failures++;
         $display("FAIL load_ack got=%b/%h exp=1/0000abcd", dm_ack, dm_rdata);
      end
      tick();
      dm_req = 1'b0;
      smp();
      checks++;
      if ({dm_ack, stall} !== 2'b00 || dm_rdata !== 32'h0000_ABCD) begin
         failures++;
         $display("FAIL load_after got=%b/%h exp=00/0000abcd", {dm_ack, stall}, dm_rdata);
      end
      tick();
   endtask

   task automatic test_simultaneous();
      int  if_cnt  = 0;
      int  if_cyc  = -1;
      int  dm_cyc  = -1;
      logic [31:0] if_seen = '0;
      logic [31:0] dm_seen = '0;
      bit  drop_if = 1'b0;
      bit  drop_dm = 1'b0;
      if_req  = 1'b1;
      if_addr = 32'h0000_0040;
      dm_req  = 1'b1;
      dm_we   = 1'b0;
      dm_addr = 32'h0000_0080;
      for (int c = 0; c < 10; c++) begin
         // memory answers in the first BUSY cycle
         mem_ack   = mem_req;
         mem_rdata = mem_addr ^ 32'h5A5A_0000;
         if (drop_if) if_req = 1'b0;
         if (drop_dm) dm_req = 1'b0;
         smp();
         if (if_ack) begin
            if_cnt++;
            if_cyc  = c;
            if_seen = if_rdata;
            drop_if = 1'b1;
         end
         if (dm_ack) begin
            dm_cyc  = c;
            dm_seen = dm_rdata;
            drop_dm = 1'b1;
         end
         tick();
      end
      mem_ack = 1'b0;
      checks++;
      if (dm_cyc !== 2 || dm_seen !== 32'h5A5A_0080) begin
         failures++;
         $display("FAIL simul_dm got=cyc%0d/%h exp=cyc2/5a5a0080", dm_cyc, dm_seen);
      end
      checks++;
      if (if_cyc !== 5 || if_seen !== 32'h5A5A_0040) begin
         failures++;
         $display("FAIL simul_if got=cyc%0d/%h exp=cyc5/5a5a0040", if_cyc, if_seen);
      end
      checks++;
      if (if_cnt !== 1) begin
         failures++;
         $display("FAIL simul_if_ack_count got=%0d exp=1", if_cnt);
      end
   endtask

   task automatic test_priority();
      logic [4:0] owners = '0;
      logic [4:0] exp_owners;
      int n = 0;
`ifdef ARB_STARVE_GUARD_EN
      exp_owners = 5'b01000; // dm, dm, dm, IF, dm (bit i = 1 means IF)
`else
      exp_owners = 5'b00000; // dm every time
`endif
      if_req  = 1'b1;
      if_addr = 32'h0000_0100;
      dm_req  = 1'b1;
      dm_we   = 1'b0;
      dm_addr = 32'h0000_0200;
      for (int c = 0; c < 15; c++) begin
         mem_ack   = mem_req;
         mem_rdata = mem_addr ^ 32'h5A5A_0000;
         smp();
         if ((if_ack || dm_ack) && n < 5) begin
            owners[n] = if_ack;
            n++;
         end
         tick();
      end
      if_req  = 1'b0;
      dm_req  = 1'b0;
      mem_ack = 1'b0;
      checks++;
      if (n !== 5 || owners !== exp_owners) begin
         failures++;
         $display("FAIL priority_seq got=n%0d/%b exp=n5/%b", n, owners, exp_owners);
      end
      tick();
   endtask

   task automatic test_reset_busy();
      int dm_acks = 0;
      // cycle 0: write granted
      dm_req   = 1'b1;
      dm_we    = 1'b1;
      dm_addr  = 32'h0000_0030;
      dm_wdata = 32'h0000_1234;
      smp();
      tick();
      // cycle 1: BUSY
      smp();
      checks++;
      if (mem_req !== 1'b1) begin
         failures++;
         $display("FAIL rstbusy_pre got=%b exp=1", mem_req);
      end
      #1 rst = 1'b1;
      #1;
      checks++;
      if ({mem_req, mem_we, if_ack, dm_ack} !== 4'b0000) begin
         failures++;
         $display("FAIL rstbusy_async got=%b exp=0000", {mem_req, mem_we, if_ack, dm_ack});
      end
      checks++;
      if ({if_rdata, dm_rdata} !== 64'h0) begin
         failures++;
         $display("FAIL rstbusy_rdata got=%h exp=0", {if_rdata, dm_rdata});
      end
      tick();
      smp();
      if (dm_ack) dm_acks++;
      tick();
      // cycle 3: release, request still pending
      rst = 1'b0;
      smp();
      if (dm_ack) dm_acks++;
      checks++;
      if (mem_req !== 1'b0) begin
         failures++;
         $display("FAIL rstbusy_idle got=%b exp=0", mem_req);
      end
      tick();
      mem_ack = 1'b1;
      smp();
      checks++;
      if ({mem_req, mem_we} !== 2'b11 || mem_addr !== 32'h30 || mem_wdata !== 32'h1234) begin
         failures++;
         $display("FAIL rstbusy_regrant got=%b/%h/%h exp=11/00000030/00001234",
                  {mem_req, mem_we}, mem_addr, mem_wdata);
      end
      checks++;
      if (dm_acks !== 0 || dm_ack !== 1'b0) begin
         failures++;
         $display("FAIL rstbusy_no_ack got=%0d exp=0", dm_acks + int'(dm_ack));
      end
      tick();
      mem_ack = 1'b0;
      smp();
      checks++;
      if (dm_ack !== 1'b1) begin
         failures++;
         $display("FAIL rstbusy_ack got=%b exp=1", dm_ack);
      end
      tick();
      dm_req = 1'b0;
      dm_we  = 1'b0;
      smp();
      tick();
   endtask

   task automatic test_spurious();
      // ack in IDLE with no request
      mem_ack   = 1'b1;
      mem_rdata = 32'hFFFF_FFFF;
      smp();
      checks++;
      if ({mem_req, if_ack, dm_ack} !== 3'b000) begin
         failures++;
         $display("FAIL spur_idle got=%b exp=000", {mem_req, if_ack, dm_ack});
      end
      tick();
      mem_ack = 1'b0;
      smp();
      checks++;
      if ({mem_req, if_ack, dm_ack} !== 3'b000) begin
         failures++;
         $display("FAIL spur_idle_next got=%b exp=000", {mem_req, if_ack, dm_ack});
      end
      tick();
      // fetch, then ack again while in DONE and after
      if_req  = 1'b1;
      if_addr = 32'h0000_0044;
      smp();
      tick();
      mem_ack   = 1'b1;
      mem_rdata = 32'h0BAD_F00D;
      smp();
      tick();
      mem_rdata = 32'h1111_2222;
      smp();
      checks++;
      if (if_ack !== 1'b1 || if_rdata !== 32'h0BAD_F00D) begin
         failures++;
         $display("FAIL spur_done_ack got=%b/%h exp=1/0badf00d", if_ack, if_rdata);
      end
      tick();
      if_req = 1'b0;
      smp();
      checks++;
      if ({if_ack, mem_req} !== 2'b00 || if_rdata !== 32'h0BAD_F00D) begin
         failures++;
         $display("FAIL spur_after_done got=%b/%h exp=00/0badf00d", {if_ack, mem_req}, if_rdata);
      end
      tick();
      mem_ack = 1'b0;
      smp();
      checks++;
      if ({if_ack, dm_ack, mem_req} !== 3'b000) begin
         failures++;
         $display("FAIL spur_final got=%b exp=000", {if_ack, dm_ack, mem_req});
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_single_fetch();
      test_store_load();
      test_simultaneous();
      test_priority();
      test_reset_busy();
      test_spurious();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
